// File: rtl/data_mem_ctrl.sv
// Data-side memory responder: one load/store in flight, word-wide array with
// read-modify-write for sub-word stores, load lane extraction and error flagging.
module data_mem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_rd_word;
  logic               r_we;
  logic [1:0]         r_lane;
  logic [IDX_W-1:0]   r_widx;
  logic [31:0]        r_wdata;
  logic [2:0]         r_load;
  logic [1:0]         r_store;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_in_word;
  logic               w_in_half;
  logic               w_err_in;
  logic               w_rsp_load;
  logic               w_rsp_err_d;
  logic [31:0]        w_rsp_data_d;
  logic [15:0]        w_half;
  logic [7:0]         w_byte;
  logic [31:0]        w_ext;
  logic [31:0]        w_wr_word;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign w_accept  = req_valid && req_ready;

  // Access size decode on the incoming request; undefined codes behave as word.
  assign w_in_word = req_we ? (store == 2'b00 || store == 2'b11)
                            : !(load == 3'b001 || load == 3'b010 || load == 3'b011 || load == 3'b100);
  assign w_in_half = req_we ? (store == 2'b01) : (load == 3'b001 || load == 3'b011);
  assign w_err_in  = (w_in_word && req_addr[1:0] != 2'b00) ||
                     (w_in_half && req_addr[0]) ||
                     (req_addr[31:2] >= 30'(DEPTH));

  assign w_half = r_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];
  assign w_byte = r_rd_word[{r_lane, 3'b000} +: 8];

  always_comb begin
    w_ext = r_rd_word;
    case (r_load)
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b011:  w_ext = {16'h0000, w_half};
      3'b100:  w_ext = {24'h000000, w_byte};
      default: w_ext = r_rd_word;
    endcase
  end

  always_comb begin
    w_wr_word = r_wdata;
    case (r_store)
      2'b01: w_wr_word = r_lane[1] ? {r_wdata[15:0], r_rd_word[15:0]}
                                   : {r_rd_word[31:16], r_wdata[15:0]};
      2'b10: begin
        w_wr_word = r_rd_word;
        w_wr_word[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      default: w_wr_word = r_wdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_rsp_load   = 1'b0;
    w_rsp_err_d  = 1'b0;
    w_rsp_data_d = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err_in) begin
            w_state_next = RESP;
            w_rsp_load   = 1'b1;
            w_rsp_err_d  = 1'b1;
          end else if (req_we && w_in_word) begin
            w_state_next = WR;
          end else begin
            w_state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          if (r_we) begin
            w_state_next = WR;
          end else begin
            w_state_next = RESP;
            w_rsp_load   = 1'b1;
            w_rsp_data_d = w_ext;
          end
        end
      end
      WR: begin
        w_state_next = RESP;
        w_rsp_load   = 1'b1;
      end
      RESP: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_lane      <= 2'b00;
      r_widx      <= '0;
      r_wdata     <= 32'h0;
      r_load      <= 3'b000;
      r_store     <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt   <= CNT_W'(RD_LAT);
        r_we    <= req_we;
        r_lane  <= req_addr[1:0];
        r_widx  <= req_addr[IDX_W+1:2];
        r_wdata <= req_wdata;
        r_load  <= load;
        r_store <= store;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_rsp_load) begin
        r_rsp_rdata <= w_rsp_data_d;
        r_rsp_err   <= w_rsp_err_d;
      end
    end
  end

  // The read is launched on the accept edge so the word is ready well before
  // RD_WAIT ends; a reset drops the state to IDLE, which cancels any pending write.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_word <= r_mem[req_addr[IDX_W+1:2]];
    end
    if (r_state == WR) begin
      r_mem[r_widx] <= w_wr_word;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// traffic compared against a byte-level memory model.
module tb_data_mem_ctrl;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  load;
  logic [1:0]  store;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [int];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .load(load), .store(store),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  function automatic int acc_size(bit we, logic [2:0] ld, logic [1:0] st);
    if (we) return (st == 2'd1) ? 2 : (st == 2'd2) ? 1 : 4;
    return (ld == 3'd1 || ld == 3'd3) ? 2 : (ld == 3'd2 || ld == 3'd4) ? 1 : 4;
  endfunction

  function automatic bit model_err(bit we, logic [31:0] addr, logic [2:0] ld, logic [1:0] st);
    int sz = acc_size(we, ld, st);
    return ((addr % sz) != 0) || ((addr >> 2) >= DEPTH);
  endfunction

  function automatic int model_lat(bit we, logic [31:0] addr, logic [2:0] ld, logic [1:0] st);
    if (model_err(we, addr, ld, st)) return 1;
    if (we) return (acc_size(we, ld, st) == 4) ? 2 : RD_LAT + 2;
    return RD_LAT + 1;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr, logic [2:0] ld);
    logic [31:0] v = word >> ((addr % 4) * 8);
    case (ld)
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd2: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd3: v = v & 32'hFFFF;
      3'd4: v = v & 32'hFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] addr,
                                              logic [31:0] data, logic [1:0] st);
    int sz = acc_size(1'b1, 3'd0, st);
    logic [31:0] mask = (sz == 4) ? 32'hFFFFFFFF : (sz == 2) ? 32'h0000FFFF : 32'h000000FF;
    int sh = (addr % 4) * 8;
    return (old & ~(mask << sh)) | ((data & mask) << sh);
  endfunction

  // Issues one request and waits for its response; lat = cycles from the accept
  // cycle to the rsp_valid cycle, or 99 if no response arrived in time.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ld, input logic [1:0] st,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; load = ld; store = st;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = 99;
    rdata = rsp_rdata;
    err   = rsp_err;
    $display("txn we=%0d addr=%h wdata=%h ld=%0d st=%0d -> rdata=%h err=%0d lat=%0d",
             we, addr, wdata, ld, st, rdata, err, lat);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    load = '0; store = '0;
    #23;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 2'd0, rd, er, lat);
    mem_model[4] = 32'hDEADBEEF;
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp: got lat=%0d err=%b rdata=%h required lat=2 err=0 rdata=0", lat, er, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_pulse: got valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
    do_req(1'b0, 32'h10, 32'h0, 3'd0, 2'd0, rd, er, lat);
    checks++;
    if (lat != RD_LAT + 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_rsp: got lat=%0d err=%b rdata=%h required lat=%0d err=0 rdata=deadbeef",
               lat, er, rd, RD_LAT + 1);
    end
  endtask

  task automatic test_rmw_byte();
    logic [31:0] rd; logic er; int lat; logic [31:0] exp_w;
    do_req(1'b1, 32'h11, 32'h0000005A, 3'd0, 2'd2, rd, er, lat);
    mem_model[4] = model_store(mem_model[4], 32'h11, 32'h5A, 2'd2);
    checks++;
    if (lat != RD_LAT + 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL sb_rsp: got lat=%0d err=%b required lat=%0d err=0", lat, er, RD_LAT + 2);
    end
    exp_w = mem_model[4];
    do_req(1'b0, 32'h10, 32'h0, 3'd0, 2'd0, rd, er, lat);
    checks++;
    if (rd !== exp_w || rd !== 32'hDEAD5AEF) begin
      errors++;
      $display("FAIL sb_merge: got %h required %h", rd, exp_w);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  ld_t  [5] = '{3'd2, 3'd2, 3'd4, 3'd1, 3'd3};
    logic [31:0] ad_t  [5] = '{32'h20, 32'h21, 32'h21, 32'h22, 32'h22};
    logic [31:0] exp_t [5] = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001};
    do_req(1'b1, 32'h20, 32'h8001F07F, 3'd0, 2'd0, rd, er, lat);
    mem_model[8] = 32'h8001F07F;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, ad_t[i], 32'h0, ld_t[i], 2'd0, rd, er, lat);
      checks++;
      if (rd !== exp_t[i] || er !== 1'b0 || lat != RD_LAT + 1) begin
        errors++;
        $display("FAIL load_ext[%0d]: got rdata=%h err=%b lat=%0d required %h 0 %0d",
                 i, rd, er, lat, exp_t[i], RD_LAT + 1);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    bit          we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad_t [3] = '{32'h13, 32'h21, DEPTH * 4};
    logic [1:0]  st_t [3] = '{2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      do_req(we_t[i], ad_t[i], 32'hFFFFFFFF, 3'd0, st_t[i], rd, er, lat);
      checks++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL err_rsp[%0d]: got lat=%0d err=%b rdata=%h required 1 1 0", i, lat, er, rd);
      end
    end
    do_req(1'b0, 32'h20, 32'h0, 3'd0, 2'd0, rd, er, lat);
    checks++;
    if (rd !== mem_model[8]) begin
      errors++;
      $display("FAIL err_nowrite: got %h required %h", rd, mem_model[8]);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int seen = 0;
    do_req(1'b1, 32'h30, 32'h11223344, 3'd0, 2'd0, rd, er, lat);
    mem_model[12] = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000AAAA; store = 2'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: got rsp_count=%0d ready=%b required 0 1", seen, req_ready);
    end
    do_req(1'b0, 32'h30, 32'h0, 3'd0, 2'd0, rd, er, lat);
    checks++;
    if (rd !== 32'h11223344) begin
      errors++;
      $display("FAIL abort_nowrite: got %h required 11223344", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] d [3];
    int rsp_cyc [$];
    int idx = 0, cyc = 0, bad_err = 0;
    bit accepting;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_we = 1'b1; store = 2'd0; req_addr = 32'h40; req_wdata = d[0];
    while (cyc < 40 && rsp_cyc.size() < 3) begin
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        if (rsp_err) bad_err++;
      end
      accepting = req_valid && req_ready;
      @(posedge clk); #1; cyc++;
      if (accepting) begin
        idx++;
        if (idx < 3) begin req_addr = 32'h40 + idx * 4; req_wdata = d[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (rsp_cyc.size() != 3 || idx != 3 || bad_err != 0) begin
      errors++;
      $display("FAIL b2b_count: got rsp=%0d accepts=%0d errs=%0d required 3 3 0",
               rsp_cyc.size(), idx, bad_err);
    end else begin
      checks++;
      if (rsp_cyc[1] - rsp_cyc[0] != 3 || rsp_cyc[2] - rsp_cyc[1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d %0d required 3 3",
                 rsp_cyc[1] - rsp_cyc[0], rsp_cyc[2] - rsp_cyc[1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      mem_model[16 + i] = d[i];
      do_req(1'b0, 32'h40 + i * 4, 32'h0, 3'd0, 2'd0, rd, er, lat);
      checks++;
      if (rd !== d[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h required %h", i, rd, d[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addr, wd, exp_rd; logic [2:0] ld; logic [1:0] st; bit we, exp_err;
    int exp_lat, widx;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      do_req(1'b1, (32'h100 + i) * 4, wd, 3'd0, 2'd0, rd, er, lat);
      mem_model[32'h100 + i] = wd;
    end
    for (int i = 0; i < 40; i++) begin
      we = $urandom_range(0, 1);
      widx = 32'h100 + $urandom_range(0, 7);
      addr = widx * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) addr = addr + DEPTH * 4;
      wd = $urandom; ld = 3'($urandom_range(0, 7)); st = 2'($urandom_range(0, 3));
      exp_err = model_err(we, addr, ld, st);
      exp_lat = model_lat(we, addr, ld, st);
      exp_rd  = (exp_err || we) ? 32'h0 : model_load(mem_model[widx], addr, ld);
      do_req(we, addr, wd, ld, st, rd, er, lat);
      if (we && !exp_err) mem_model[widx] = model_store(mem_model[widx], addr, wd, st);
      checks++;
      if (rd !== exp_rd || er !== exp_err || lat != exp_lat) begin
        errors++;
        $display("FAIL rand[%0d]: got rdata=%h err=%b lat=%0d required %h %b %0d",
                 i, rd, er, lat, exp_rd, exp_err, exp_lat);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, (32'h100 + i) * 4, 32'h0, 3'd0, 2'd0, rd, er, lat);
      checks++;
      if (rd !== mem_model[32'h100 + i]) begin
        errors++;
        $display("FAIL rand_final[%0d]: got %h required %h", i, rd, mem_model[32'h100 + i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_rmw_byte();
    test_load_ext();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Memory-side responder for the multi-cycle core's data-access requests. Accepts one load or store at a time, each tagged with the core's load code (3-bit) and store code (2-bit). Owns a word-wide single-port data array that can only be written as whole words, so it performs read-modify-write for SH/SB. Performs lane selection and sign/zero extension for loads, and flags misaligned or out-of-range accesses.

Parameters:
DEPTH, 1024, number of 32-bit words in the data array (power of two).
RD_LAT, 2, array read latency in cycles (must be >= 1).

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; lane data is in the low bits (SH uses [15:0], SB uses [7:0])
load  input  3  load code: LW=000, LH=001, LB=010, LHU=011, LBU=100; 101-111 are treated as LW
store  input  2  store code: SW=00, SH=01, SB=10; 11 is treated as SW
rsp_valid  output  1  one-cycle completion pulse, for both loads and stores
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  qualified by rsp_valid; access was misaligned or out of range

Behaviour:
- FSM states: IDLE, RD_WAIT, WR, RESP.
- req_ready = (state == IDLE).
- Accept cycle T: a request is accepted when req_valid && req_ready.
  - At acceptance, req_we, req_addr, req_wdata, load and store are registered.
  - Inputs are ignored outside acceptance.
- Address fields: widx = addr[31:2], lane = addr[1:0].
- Error check, evaluated at acceptance:
  - Misaligned: word access with lane != 0, or half access with lane[0] = 1.
  - Out of range: widx >= DEPTH.
  - On error: no array access, state goes IDLE -> RESP, so rsp_valid is high in T+1 with rsp_err = 1 and rsp_rdata = 0.
- Load:
  - RD_WAIT for RD_LAT cycles (T+1 .. T+RD_LAT), using a down-counter.
  - RESP in T+RD_LAT+1 with extended data.
  - LW returns the full word.
  - LH/LHU return half [15:0] if lane = 0, or [31:16] if lane = 2.
  - LB/LBU return byte lane*8 +: 8.
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Store SW: WR in T+1, writing req_wdata to the array at the end of T+1; RESP in T+2.
- Store SH/SB (read-modify-write):
  - RD_WAIT for T+1 .. T+RD_LAT.
  - WR in T+RD_LAT+1: the read word is merged with the new lane(s); all other bytes are preserved bit-exact.
  - RESP in T+RD_LAT+2.
- RESP always returns to IDLE, so req_ready is high in the cycle after rsp_valid.
- Back-to-back: at most one request in flight. A request held on req_valid during the busy states is accepted in the first IDLE cycle.
- rsp_valid is a single-cycle pulse; there is no backpressure. rsp_rdata and rsp_err hold their values until the next RESP.
- Array writes occur only on the clock edge that ends the WR state, as one whole word per write.
- Reset (rstn low, asynchronous):
  - State -> IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1.
  - Array contents are not reset.
  - Reset asserted mid-operation aborts the request. If rstn falls before the WR edge, the array is unchanged; no partial write is ever visible.
  - No rsp_valid is generated for an aborted request.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp_valid at T+2 with err 0; load rsp_valid at T+3 (RD_LAT=2) with rdata 0xDEADBEEF.
- After the SW above: SB 0x5A @0x11, then LW @0x10 -> SB response at T+4; LW returns 0xDEAD5AEF; bytes 0, 2 and 3 unchanged.
- Loads of word 0x8001F07F @0x20:
  - LB @0x20 -> 0x0000007F.
  - LB @0x21 -> 0xFFFFFFF0.
  - LBU @0x21 -> 0x000000F0.
  - LH @0x22 -> 0xFFFF8001.
  - LHU @0x22 -> 0x00008001.
- Misaligned LW @0x13, SH @0x21, and a load at word index DEPTH -> rsp_valid at T+1 with err 1, rdata 0, and the array is unchanged (checked by a later LW).
- Reset pulse during the RD_WAIT of an SH @0x30 (old word 0x11223344) -> no rsp_valid; req_ready is 1 after reset; LW @0x30 returns 0x11223344.
- req_valid held high for 3 back-to-back SW requests -> each is accepted only when req_ready = 1, with exactly one rsp_valid per request, in order and spaced 3 cycles apart.
